// File: rtl/single_port_ram_ctrl.sv
// single_port_ram_ctrl
// Request/response front end for a single-port synchronous RAM whose read
// data (Q) appears the cycle after the address is presented. Reads take two
// cycles from accept to response beat, writes complete in the accept cycle.
//
// Build option: define SINGLE_PORT_RAM_CTRL_WRITE_ACK_EN to make every
// accepted write return a response beat one cycle later carrying the written
// data. Without it, writes produce no response beat.
module single_port_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  // response channel
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  // RAM side
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // IDLE: nothing outstanding; RD: RAM is producing Q for the accepted read;
  // RESP: a response beat is being offered.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;   // last accepted address, keeps the RAM read port steady
  logic                  accept;

  // Handshake and RAM drive; a new request may enter when idle or when the
  // current response beat is being consumed. Reset blocks all acceptance so no
  // write can leak into the RAM while the controller is being cleared.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    req_ready = 1'b0;
    accept    = 1'b0;
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_d     = req_data;
    if (!RST) begin
      req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
    end
    accept = req_valid && req_ready;
    if (accept) begin
      ram_addr = req_addr;
      ram_we   = req_we;
    end
  end

  // Controller state, held address and registered response beat.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, matching flip-flop behaviour.
    if (RST) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      addr_q     <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
      end

      unique case (state)
        // IDLE behaves like RESP with the beat already consumed, so both share
        // the same next-request decision.
        IDLE, RESP: begin
          if ((state == IDLE) || resp_ready) begin
            if (!accept) begin
              state      <= IDLE;
              resp_valid <= 1'b0;
            end else if (!req_we) begin
              state      <= RD;
              resp_valid <= 1'b0;
            end else begin
`ifdef SINGLE_PORT_RAM_CTRL_WRITE_ACK_EN
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= req_data;
`else
              state      <= IDLE;
              resp_valid <= 1'b0;
`endif
            end
          end
        end

        // The address was registered by the RAM on the accept edge, so Q is
        // valid now and is the only point where it is sampled.
        RD: begin
          resp_data  <= ram_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
